// File: rtl/prbs_edge_shaper_mc.sv
// prbs_edge_shaper_mc
// Turns a 1-bit PRBS stream into DATA_W-bit DAC samples. Each transition of the valid bit
// stream launches a ramp between programmable low/high levels. The ramp uses a
// fixed-point accumulator (FRAC_W fractional bits) and has independent rise/fall durations
// and steps. A request in the opposite direction during a ramp reverses it from the current
// sample. Configuration is taken from shadow registers loaded by cfg_load.
// Optional build macro: PRBS_SHAPER_EDGE_CNT_EN adds rise_cnt/fall_cnt request counters.
module prbs_edge_shaper_mc #(
    parameter int DATA_W = 16,
    parameter int TIME_W = 8,
    parameter int FRAC_W = 8
) (
    input  logic                       dac_clk,
    input  logic                       reset,
    input  logic                       bit_in,
    input  logic                       bit_valid,
    input  logic [DATA_W-1:0]          cfg_level_hi,
    input  logic [DATA_W-1:0]          cfg_level_lo,
    input  logic [TIME_W-1:0]          cfg_rise_cycles,
    input  logic [TIME_W-1:0]          cfg_fall_cycles,
    input  logic [DATA_W+FRAC_W-1:0]   cfg_rise_step,
    input  logic [DATA_W+FRAC_W-1:0]   cfg_fall_step,
    input  logic                       cfg_load,
    output logic [DATA_W-1:0]          dout,
    output logic                       edge_busy,
    output logic                       reversal,
    output logic                       cfg_err,
    output logic [1:0]                 state_dbg
`ifdef PRBS_SHAPER_EDGE_CNT_EN
    ,
    output logic [31:0]                rise_cnt,
    output logic [31:0]                fall_cnt
`endif
);

    localparam int ACC_W = DATA_W + FRAC_W;
    localparam logic [TIME_W-1:0] TWO_CYC = TIME_W'(2);
    localparam logic [DATA_W-1:0] HI_RST  = {1'b0, {(DATA_W-1){1'b1}}};

    typedef enum logic [1:0] {
        ST_LOW  = 2'b00,
        ST_RISE = 2'b01,
        ST_HIGH = 2'b10,
        ST_FALL = 2'b11
    } state_t;

    // Place an integer level at the accumulator's binary point.
    function automatic logic [ACC_W-1:0] level_to_acc(input logic [DATA_W-1:0] lvl);
        return {lvl, {FRAC_W{1'b0}}};
    endfunction

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [TIME_W-1:0]   cnt_q, cnt_d;
    logic                prev_bit_q;
    logic [DATA_W-1:0]   dout_q;
    logic                edge_busy_q, edge_busy_d;
    logic                reversal_q, reversal_d;
    logic                cfg_err_q;

    // Shadowed configuration used by the ramps
    logic [DATA_W-1:0]   lo_q, hi_q;
    logic [TIME_W-1:0]   rise_cyc_q, fall_cyc_q;
    logic [ACC_W-1:0]    rise_step_q, fall_step_q;

    logic                rise_req_s, fall_req_s, cfg_ok_s;
    logic [ACC_W-1:0]    lo_acc_s, hi_acc_s;
    logic [ACC_W:0]      rise_sum_s, fall_diff_s;
    logic                rise_hit_s, fall_hit_s;
    logic [ACC_W-1:0]    rise_acc_s, fall_acc_s;
    logic [TIME_W:0]     cnt_inc_s;
    logic                rise_done_s, fall_done_s;

    // Only sampled bits count as edges; prev_bit_q tracks the last sampled bit.
    assign rise_req_s = bit_valid &  bit_in & ~prev_bit_q;
    assign fall_req_s = bit_valid & ~bit_in &  prev_bit_q;
    assign cfg_ok_s   = (cfg_level_hi >= cfg_level_lo);

    assign lo_acc_s = level_to_acc(lo_q);
    assign hi_acc_s = level_to_acc(hi_q);

    // One extra bit keeps the add carry / subtract borrow so the clamp never sees a wrap.
    assign rise_sum_s  = {1'b0, acc_q} + {1'b0, rise_step_q};
    assign fall_diff_s = {1'b0, acc_q} - {1'b0, fall_step_q};
    assign rise_hit_s  = (rise_sum_s >= {1'b0, hi_acc_s});
    assign fall_hit_s  = fall_diff_s[ACC_W] | (fall_diff_s[ACC_W-1:0] <= lo_acc_s);
    assign rise_acc_s  = rise_hit_s ? hi_acc_s : rise_sum_s[ACC_W-1:0];
    assign fall_acc_s  = fall_hit_s ? lo_acc_s : fall_diff_s[ACC_W-1:0];

    // Ramp ends after the programmed number of cycles; the >= form also ends a ramp
    // promptly if the duration is reprogrammed shorter while it is running.
    assign cnt_inc_s   = {1'b0, cnt_q} + {{TIME_W{1'b0}}, 1'b1};
    assign rise_done_s = (cnt_inc_s >= {1'b0, rise_cyc_q});
    assign fall_done_s = (cnt_inc_s >= {1'b0, fall_cyc_q});

    // Next-state, accumulator and edge counter logic of the shaper FSM.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        reversal_d = 1'b0;
        case (state_q)
            ST_LOW: begin
                acc_d = lo_acc_s;
                if (rise_req_s) begin
                    cnt_d = {TIME_W{1'b0}};
                    if (rise_cyc_q >= TWO_CYC) begin
                        state_d = ST_RISE;
                    end else begin
                        state_d = ST_HIGH;
                    end
                end else begin
                    state_d = ST_LOW;
                end
            end
            ST_RISE: begin
                acc_d = rise_acc_s;
                cnt_d = cnt_inc_s[TIME_W-1:0];
                if (fall_req_s) begin
                    // Reverse from the sample just produced, so dout never jumps.
                    state_d    = ST_FALL;
                    cnt_d      = {TIME_W{1'b0}};
                    reversal_d = 1'b1;
                end else if (rise_hit_s || rise_done_s) begin
                    state_d = ST_HIGH;
                    acc_d   = hi_acc_s;
                end else begin
                    state_d = ST_RISE;
                end
            end
            ST_HIGH: begin
                acc_d = hi_acc_s;
                if (fall_req_s) begin
                    cnt_d = {TIME_W{1'b0}};
                    if (fall_cyc_q >= TWO_CYC) begin
                        state_d = ST_FALL;
                    end else begin
                        state_d = ST_LOW;
                    end
                end else begin
                    state_d = ST_HIGH;
                end
            end
            ST_FALL: begin
                acc_d = fall_acc_s;
                cnt_d = cnt_inc_s[TIME_W-1:0];
                if (rise_req_s) begin
                    state_d    = ST_RISE;
                    cnt_d      = {TIME_W{1'b0}};
                    reversal_d = 1'b1;
                end else if (fall_hit_s || fall_done_s) begin
                    state_d = ST_LOW;
                    acc_d   = lo_acc_s;
                end else begin
                    state_d = ST_FALL;
                end
            end
            default: begin
                state_d = ST_LOW;
                acc_d   = lo_acc_s;
                cnt_d   = {TIME_W{1'b0}};
            end
        endcase
        edge_busy_d = (state_d == ST_RISE) || (state_d == ST_FALL);
    end

    // FSM state, accumulator and registered outputs.
    always_ff @(posedge dac_clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_LOW;
            acc_q       <= {ACC_W{1'b0}};
            cnt_q       <= {TIME_W{1'b0}};
            dout_q      <= {DATA_W{1'b0}};
            edge_busy_q <= 1'b0;
            reversal_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            dout_q      <= acc_d[ACC_W-1:FRAC_W];
            edge_busy_q <= edge_busy_d;
            reversal_q  <= reversal_d;
        end
    end

    // Last sampled PRBS bit, advanced only when the LFSR shifts.
    always_ff @(posedge dac_clk or posedge reset) begin
        if (reset) begin
            prev_bit_q <= 1'b0;
        end else if (bit_valid) begin
            prev_bit_q <= bit_in;
        end
    end

    // Shadow configuration capture; an inverted level pair is refused and flagged.
    always_ff @(posedge dac_clk or posedge reset) begin
        if (reset) begin
            lo_q        <= {DATA_W{1'b0}};
            hi_q        <= HI_RST;
            rise_cyc_q  <= {TIME_W{1'b0}};
            fall_cyc_q  <= {TIME_W{1'b0}};
            rise_step_q <= {ACC_W{1'b0}};
            fall_step_q <= {ACC_W{1'b0}};
            cfg_err_q   <= 1'b0;
        end else begin
            cfg_err_q <= cfg_load & ~cfg_ok_s;
            if (cfg_load && cfg_ok_s) begin
                lo_q        <= cfg_level_lo;
                hi_q        <= cfg_level_hi;
                rise_cyc_q  <= cfg_rise_cycles;
                fall_cyc_q  <= cfg_fall_cycles;
                rise_step_q <= cfg_rise_step;
                fall_step_q <= cfg_fall_step;
            end
        end
    end

`ifdef PRBS_SHAPER_EDGE_CNT_EN
    logic [31:0] rise_cnt_q, fall_cnt_q;

    // Count accepted rise/fall requests, reversals included; wraps at 2^32.
    always_ff @(posedge dac_clk or posedge reset) begin
        if (reset) begin
            rise_cnt_q <= 32'd0;
            fall_cnt_q <= 32'd0;
        end else begin
            if (rise_req_s && ((state_q == ST_LOW) || (state_q == ST_FALL))) begin
                rise_cnt_q <= rise_cnt_q + 32'd1;
            end
            if (fall_req_s && ((state_q == ST_HIGH) || (state_q == ST_RISE))) begin
                fall_cnt_q <= fall_cnt_q + 32'd1;
            end
        end
    end

    assign rise_cnt = rise_cnt_q;
    assign fall_cnt = fall_cnt_q;
`else
    // Request counters are not built in this configuration.
`endif

    assign dout      = dout_q;
    assign edge_busy = edge_busy_q;
    assign reversal  = reversal_q;
    assign cfg_err   = cfg_err_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_prbs_edge_shaper_mc.sv
// Bench for prbs_edge_shaper_mc: directed vector table, hand-written multi-cycle
// sequences and a randomized run against a cycle-level reference model.
module tb_prbs_edge_shaper_mc;
    localparam int DATA_W = 16;
    localparam int TIME_W = 8;
    localparam int FRAC_W = 8;
    localparam int TBL_N  = 11;

    logic                      dac_clk = 1'b0;
    logic                      reset;
    logic                      bit_in, bit_valid, cfg_load;
    logic [DATA_W-1:0]         cfg_level_hi, cfg_level_lo;
    logic [TIME_W-1:0]         cfg_rise_cycles, cfg_fall_cycles;
    logic [DATA_W+FRAC_W-1:0]  cfg_rise_step, cfg_fall_step;
    logic [DATA_W-1:0]         dout;
    logic                      edge_busy, reversal, cfg_err;
    logic [1:0]                state_dbg;
`ifdef PRBS_SHAPER_EDGE_CNT_EN
    logic [31:0]               rise_cnt, fall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    prbs_edge_shaper_mc #(.DATA_W(DATA_W), .TIME_W(TIME_W), .FRAC_W(FRAC_W)) dut (
        .dac_clk         (dac_clk),
        .reset           (reset),
        .bit_in          (bit_in),
        .bit_valid       (bit_valid),
        .cfg_level_hi    (cfg_level_hi),
        .cfg_level_lo    (cfg_level_lo),
        .cfg_rise_cycles (cfg_rise_cycles),
        .cfg_fall_cycles (cfg_fall_cycles),
        .cfg_rise_step   (cfg_rise_step),
        .cfg_fall_step   (cfg_fall_step),
        .cfg_load        (cfg_load),
        .dout            (dout),
        .edge_busy       (edge_busy),
        .reversal        (reversal),
        .cfg_err         (cfg_err),
        .state_dbg       (state_dbg)
`ifdef PRBS_SHAPER_EDGE_CNT_EN
        ,
        .rise_cnt        (rise_cnt),
        .fall_cnt        (fall_cnt)
`endif
    );

    always #5 dac_clk = ~dac_clk;

    // Reference model: the output heads toward a target level, either resting on it or
    // moving toward it by whole steps; all arithmetic in plain 64-bit integers.
    longint      m_lo, m_hi, m_rs, m_fs, m_acc;
    int          m_rc, m_fc, m_elapsed;
    bit          m_prev, m_tgt_hi, m_moving, m_rev, m_err;
    int unsigned m_rcnt, m_fcnt;

    task automatic model_reset();
        m_lo = 0; m_hi = 32767; m_rs = 0; m_fs = 0; m_rc = 0; m_fc = 0;
        m_acc = 0; m_elapsed = 0; m_prev = 1'b0; m_tgt_hi = 1'b0; m_moving = 1'b0;
        m_rev = 1'b0; m_err = 1'b0; m_rcnt = 0; m_fcnt = 0;
    endtask

    task automatic model_edge();
        bit     rr, fr, hit, done;
        longint top, bot, nxt;
        rr  = bit_valid && bit_in && !m_prev;
        fr  = bit_valid && !bit_in && m_prev;
        top = m_hi * 256;
        bot = m_lo * 256;
        m_rev = 1'b0;
        if (!m_moving) begin
            m_acc = m_tgt_hi ? top : bot;
            if (!m_tgt_hi && rr) begin
                m_tgt_hi = 1'b1; m_moving = (m_rc >= 2); m_elapsed = 0; m_rcnt++;
            end else if (m_tgt_hi && fr) begin
                m_tgt_hi = 1'b0; m_moving = (m_fc >= 2); m_elapsed = 0; m_fcnt++;
            end
        end else begin
            m_elapsed++;
            if (m_tgt_hi) begin
                nxt = m_acc + m_rs; hit = (nxt >= top); m_acc = hit ? top : nxt;
                done = hit || (m_elapsed >= m_rc);
            end else begin
                nxt = m_acc - m_fs; hit = (nxt <= bot); m_acc = hit ? bot : nxt;
                done = hit || (m_elapsed >= m_fc);
            end
            if (m_tgt_hi && fr) begin
                m_tgt_hi = 1'b0; m_elapsed = 0; m_rev = 1'b1; m_fcnt++;
            end else if (!m_tgt_hi && rr) begin
                m_tgt_hi = 1'b1; m_elapsed = 0; m_rev = 1'b1; m_rcnt++;
            end else if (done) begin
                m_moving = 1'b0; m_acc = m_tgt_hi ? top : bot;
            end
        end
        if (bit_valid) m_prev = bit_in;
        m_err = cfg_load && (cfg_level_hi < cfg_level_lo);
        if (cfg_load && (cfg_level_hi >= cfg_level_lo)) begin
            m_lo = longint'(cfg_level_lo);      m_hi = longint'(cfg_level_hi);
            m_rc = int'(cfg_rise_cycles);       m_fc = int'(cfg_fall_cycles);
            m_rs = longint'(cfg_rise_step);     m_fs = longint'(cfg_fall_step);
        end
    endtask

    task automatic check_model();
        logic [15:0] ed;
        logic [1:0]  es;
        ed = 16'(m_acc / 256);
        es = m_moving ? (m_tgt_hi ? 2'b01 : 2'b11) : (m_tgt_hi ? 2'b10 : 2'b00);
        total++;
        if (dout !== ed || state_dbg !== es || edge_busy !== m_moving ||
            reversal !== m_rev || cfg_err !== m_err) begin
            bad++;
            $display("FAIL model @%0t: got dout=%h st=%b busy=%b rev=%b err=%b want dout=%h st=%b busy=%b rev=%b err=%b",
                     $time, dout, state_dbg, edge_busy, reversal, cfg_err, ed, es, m_moving, m_rev, m_err);
        end
`ifdef PRBS_SHAPER_EDGE_CNT_EN
        total++;
        if (rise_cnt !== m_rcnt || fall_cnt !== m_fcnt) begin
            bad++;
            $display("FAIL model_cnt @%0t: got rise=%0d fall=%0d want rise=%0d fall=%0d",
                     $time, rise_cnt, fall_cnt, m_rcnt, m_fcnt);
        end
`endif
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Drive inputs at the falling edge, step the model at the rising edge, compare at the next falling edge.
    task automatic tick(input bit v, input bit b, input bit ld);
        bit_valid = v; bit_in = b; cfg_load = ld;
        @(posedge dac_clk);
        model_edge();
        @(negedge dac_clk);
        check_model();
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (edge_busy === 1'b1 && n < budget) begin
            tick(1'b0, 1'b0, 1'b0);
            n++;
        end
        chk(name, {31'd0, edge_busy}, 32'd0);
    endtask

    typedef struct {
        bit          v;
        bit          b;
        bit          ld;
        logic [15:0] dout;
        logic [1:0]  st;
        bit          busy;
        bit          err;
    } vec_t;

    vec_t tbl [TBL_N];

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        // Defaults step (vec 0-2), config load (3-4), 4-cycle rise 0x1000->0x5000 (5-10)
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 2'b10, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 16'h7FFF, 2'b10, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 16'h7FFF, 2'b00, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 2'b00, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 16'h1000, 2'b00, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 16'h1000, 2'b01, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 16'h2000, 2'b01, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 16'h3000, 2'b01, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 16'h4000, 2'b01, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 16'h5000, 2'b10, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 16'h5000, 2'b10, 1'b0, 1'b0};

        reset = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; cfg_load = 1'b0;
        cfg_level_lo = 16'h1000; cfg_level_hi = 16'h5000;
        cfg_rise_cycles = 8'd4;  cfg_fall_cycles = 8'd8;
        cfg_rise_step = 24'h100000; cfg_fall_step = 24'h080000;
        model_reset();
        repeat (2) @(negedge dac_clk);
        chk("rst_dout", {16'd0, dout}, 32'h0000);
        chk("rst_flags", {28'd0, state_dbg, edge_busy, reversal}, 32'd0);
        chk("rst_err", {31'd0, cfg_err}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < TBL_N; i++) begin
            tick(tbl[i].v, tbl[i].b, tbl[i].ld);
            chk($sformatf("vec%0d", i), {12'd0, dout, state_dbg, edge_busy, cfg_err},
                {12'd0, tbl[i].dout, tbl[i].st, tbl[i].busy, tbl[i].err});
        end

        // Reversal: fall request while rise counter is 1
        tick(1'b1, 1'b0, 1'b0);
        wait_idle(40, "t3_settle");
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chk("t3_rise0", {16'd0, dout}, 32'h2000);
        tick(1'b1, 1'b0, 1'b0);
        chk("t3_rev", {13'd0, dout, reversal, state_dbg}, {13'd0, 16'h3000, 1'b1, 2'b11});
        for (int k = 0; k < 4; k++) begin
            tick(1'b0, 1'b0, 1'b0);
            chk($sformatf("t3_fall%0d", k), {14'd0, dout, state_dbg},
                {14'd0, 16'(32'h3000 - 32'h0800 * (k + 1)), (k == 3) ? 2'b00 : 2'b11});
        end

        // Rejected config: shadows keep lo=0x1000 hi=0x5000
        cfg_level_hi = 16'h1000; cfg_level_lo = 16'h2000;
        tick(1'b0, 1'b0, 1'b1);
        chk("t4_err", {31'd0, cfg_err}, 32'd1);
        tick(1'b0, 1'b0, 1'b0);
        chk("t4_err_clr", {15'd0, dout, cfg_err}, {15'd0, 16'h1000, 1'b0});
        tick(1'b1, 1'b1, 1'b0);
        wait_idle(40, "t4_settle");
        chk("t4_hi", {14'd0, dout, state_dbg}, {14'd0, 16'h5000, 2'b10});

        // Bits without valid are ignored
        for (int k = 0; k < 6; k++) begin
            tick(1'b0, 1'(k % 2), 1'b0);
            chk($sformatf("t5_hold%0d", k), {14'd0, dout, state_dbg}, {14'd0, 16'h5000, 2'b10});
        end
        tick(1'b1, 1'b0, 1'b0);
        wait_idle(40, "t5_settle");
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chk("t5_midrise", {14'd0, dout, state_dbg}, {14'd0, 16'h2000, 2'b01});
        #2 reset = 1'b1;
        #1 chk("t5_rst_now", {14'd0, dout, state_dbg}, 32'd0);
        model_reset();
        bit_valid = 1'b0; cfg_load = 1'b0;
        @(negedge dac_clk);
        chk("t5_rst_next", {13'd0, dout, state_dbg, edge_busy}, 32'd0);
        reset = 1'b0;

`ifdef PRBS_SHAPER_EDGE_CNT_EN
        for (int k = 0; k < 10; k++) tick(1'b1, 1'((k + 1) % 2), 1'b0);
        chk("t6_rise_cnt", rise_cnt, 32'd5);
        chk("t6_fall_cnt", fall_cnt, 32'd5);
`endif

        // Randomized traffic with occasional (sometimes invalid) reconfiguration
        for (int i = 0; i < 900; i++) begin
            bit     ld;
            longint h, l, t;
            ld = ($urandom_range(0, 15) == 0);
            if (ld) begin
                h = longint'($urandom_range(0, 65535));
                l = longint'($urandom_range(0, 32'(h)));
                cfg_rise_cycles = 8'($urandom_range(0, 12));
                cfg_fall_cycles = 8'($urandom_range(0, 12));
                if (cfg_rise_cycles >= 8'd2) cfg_rise_step = 24'(((h - l) * 256) / cfg_rise_cycles);
                else cfg_rise_step = 24'($urandom);
                if (cfg_fall_cycles >= 8'd2) cfg_fall_step = 24'(((h - l) * 256) / cfg_fall_cycles);
                else cfg_fall_step = 24'($urandom);
                if ($urandom_range(0, 5) == 0) cfg_rise_step = 24'($urandom);
                if ($urandom_range(0, 7) == 0) begin
                    t = h; h = l; l = t;
                end
                cfg_level_hi = 16'(h);
                cfg_level_lo = 16'(l);
            end
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ld);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
